// File: rtl/wb_commit_buffer_if.sv
// Bus between the memory stage, the commit buffer, the register-file write ports and decode.
interface wb_commit_buffer_if #(
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned AWIDTH       = 5,
  parameter int unsigned FUNCT_WIDTH  = 3,
  parameter int unsigned OPCODE_WIDTH = 7,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned NPORTS       = 2
);
  logic                        wb_i_ce;
  logic [OPCODE_WIDTH-1:0]     wb_i_opcode;
  logic [FUNCT_WIDTH-1:0]      wb_i_funct;
  logic                        wb_i_we_rd;
  logic [AWIDTH-1:0]           wb_i_rd_addr;
  logic [DWIDTH-1:0]           wb_i_rd_data;
  logic [DWIDTH-1:0]           wb_i_data_load;
  logic [1:0]                  wb_i_byte_off;
  logic                        wb_i_flush;
  logic [NPORTS-1:0]           wb_i_rf_ready;
  logic [AWIDTH-1:0]           wb_i_fwd_addr;
  logic                        wb_o_stall;
  logic [NPORTS-1:0]           wb_o_we;
  logic [NPORTS*AWIDTH-1:0]    wb_o_rd_addr;
  logic [NPORTS*DWIDTH-1:0]    wb_o_rd_data;
  logic                        wb_o_fwd_hit;
  logic [DWIDTH-1:0]           wb_o_fwd_data;
  logic [$clog2(DEPTH):0]      wb_o_count;

  modport master (
    output wb_i_ce, wb_i_opcode, wb_i_funct, wb_i_we_rd, wb_i_rd_addr, wb_i_rd_data,
           wb_i_data_load, wb_i_byte_off, wb_i_flush, wb_i_rf_ready, wb_i_fwd_addr,
    input  wb_o_stall, wb_o_we, wb_o_rd_addr, wb_o_rd_data, wb_o_fwd_hit, wb_o_fwd_data,
           wb_o_count
  );

  modport slave (
    input  wb_i_ce, wb_i_opcode, wb_i_funct, wb_i_we_rd, wb_i_rd_addr, wb_i_rd_data,
           wb_i_data_load, wb_i_byte_off, wb_i_flush, wb_i_rf_ready, wb_i_fwd_addr,
    output wb_o_stall, wb_o_we, wb_o_rd_addr, wb_o_rd_data, wb_o_fwd_hit, wb_o_fwd_data,
           wb_o_count
  );
endinterface

// File: rtl/wb_commit_buffer.sv
// Write-back commit buffer: formats loads, queues rd writes in order and retires
// up to NPORTS per cycle through independently-ready register-file ports.
module wb_commit_buffer #(
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned AWIDTH       = 5,
  parameter int unsigned FUNCT_WIDTH  = 3,
  parameter int unsigned OPCODE_WIDTH = 7,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned NPORTS       = 2
) (
  input logic              wb_clk,
  input logic              wb_rst,
  wb_commit_buffer_if.slave bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD = OPCODE_WIDTH'(7'b0000011);

  logic [AWIDTH-1:0]        mem_addr [DEPTH];
  logic [DWIDTH-1:0]        mem_data [DEPTH];
  logic [PW-1:0]            head, tail;
  logic [CW-1:0]            count;

  logic                     stall;
  logic                     accept;
  logic [7:0]               ld_byte;
  logic [15:0]              ld_half;
  logic [DWIDTH-1:0]        in_data;

  logic [NPORTS-1:0]        retire, we;
  logic [CW-1:0]            nret;
  logic [NPORTS*AWIDTH-1:0] lane_addr;
  logic [NPORTS*DWIDTH-1:0] lane_data;
  logic [PW-1:0]            lane_idx;
  logic                     prefix;

  logic                     fwd_hit;
  logic [DWIDTH-1:0]        fwd_data;
  logic [PW-1:0]            fwd_idx;

  assign stall  = (count == CW'(DEPTH));
  assign accept = bus.wb_i_ce & bus.wb_i_we_rd & (bus.wb_i_rd_addr != '0)
                & ~bus.wb_i_flush & ~stall;

  always_comb begin
    ld_byte = bus.wb_i_data_load[{bus.wb_i_byte_off, 3'b000} +: 8];
    ld_half = bus.wb_i_data_load[{bus.wb_i_byte_off[1], 4'b0000} +: 16];
    in_data = bus.wb_i_rd_data;
    if (bus.wb_i_opcode == OP_LOAD) begin
      case (bus.wb_i_funct[2:0])
        3'b000:  in_data = {{(DWIDTH-8){ld_byte[7]}}, ld_byte};
        3'b001:  in_data = {{(DWIDTH-16){ld_half[15]}}, ld_half};
        3'b100:  in_data = {{(DWIDTH-8){1'b0}}, ld_byte};
        3'b101:  in_data = {{(DWIDTH-16){1'b0}}, ld_half};
        default: in_data = bus.wb_i_data_load;
      endcase
    end
  end

  // Lanes retire as a strict in-order prefix of the presented entries.
  always_comb begin
    retire    = '0;
    nret      = '0;
    lane_addr = '0;
    lane_data = '0;
    lane_idx  = '0;
    prefix    = 1'b1;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      lane_idx = head + PW'(k);
      if (CW'(k) < count) begin
        lane_addr[k*AWIDTH +: AWIDTH] = mem_addr[lane_idx];
        lane_data[k*DWIDTH +: DWIDTH] = mem_data[lane_idx];
        retire[k] = prefix & bus.wb_i_rf_ready[k];
      end
      prefix = retire[k];
      if (retire[k]) nret = nret + CW'(1);
    end
  end

  // An older lane shadowed by a younger retiring write to the same register
  // still retires, but its port enable is dropped so only the youngest lands.
  always_comb begin
    we = retire;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      for (int unsigned j = i + 1; j < NPORTS; j++) begin
        if (retire[i] && retire[j] &&
            lane_addr[i*AWIDTH +: AWIDTH] == lane_addr[j*AWIDTH +: AWIDTH])
          we[i] = 1'b0;
      end
    end
  end

  // Walk oldest to youngest so the youngest buffered match wins; the incoming
  // accepted result overrides everything.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_idx = head + PW'(k);
      if (CW'(k) < count && mem_addr[fwd_idx] == bus.wb_i_fwd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_data[fwd_idx];
      end
    end
    if (accept && bus.wb_i_rd_addr == bus.wb_i_fwd_addr) begin
      fwd_hit  = 1'b1;
      fwd_data = in_data;
    end
    if (bus.wb_i_fwd_addr == '0) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(nret);
      tail  <= tail + PW'(accept);
      count <= count + CW'(accept) - nret;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (accept) begin
      mem_addr[tail] <= bus.wb_i_rd_addr;
      mem_data[tail] <= in_data;
    end
  end

  assign bus.wb_o_stall    = stall;
  assign bus.wb_o_we       = we;
  assign bus.wb_o_rd_addr  = lane_addr;
  assign bus.wb_o_rd_data  = lane_data;
  assign bus.wb_o_fwd_hit  = fwd_hit;
  assign bus.wb_o_fwd_data = fwd_data;
  assign bus.wb_o_count    = count;
endmodule

// File: tb/tb_wb_commit_buffer.sv
// Randomized and directed bench for wb_commit_buffer against a queue-based reference model.
module tb_wb_commit_buffer;
  localparam int unsigned DW = 32, AW = 5, FW = 3, OW = 7, DEPTH = 4, NP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_commit_buffer_if #(.DWIDTH(DW), .AWIDTH(AW), .FUNCT_WIDTH(FW), .OPCODE_WIDTH(OW),
                        .DEPTH(DEPTH), .NPORTS(NP)) bus ();

  wb_commit_buffer #(.DWIDTH(DW), .AWIDTH(AW), .FUNCT_WIDTH(FW), .OPCODE_WIDTH(OW),
                     .DEPTH(DEPTH), .NPORTS(NP)) dut (
    .wb_clk (clk),
    .wb_rst (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_value(input logic [6:0] op, input logic [2:0] f,
                                             input logic [31:0] rdd, input logic [31:0] raw,
                                             input logic [1:0] off);
    logic [31:0] b, h;
    if (op != 7'b0000011) return rdd;
    b = (raw >> (32'(off) * 8)) & 32'hFF;
    h = (raw >> (32'(off[1]) * 16)) & 32'hFFFF;
    case (f)
      3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return raw;
    endcase
  endfunction

  task automatic drive(input logic ce, input logic [6:0] op, input logic [2:0] f,
                       input logic [4:0] rd, input logic [31:0] rdd, input logic [31:0] ld,
                       input logic [1:0] off, input logic fl, input logic [1:0] rdy,
                       input logic [4:0] fa);
    bus.wb_i_ce        = ce;
    bus.wb_i_opcode    = op;
    bus.wb_i_funct     = f;
    bus.wb_i_we_rd     = 1'b1;
    bus.wb_i_rd_addr   = rd;
    bus.wb_i_rd_data   = rdd;
    bus.wb_i_data_load = ld;
    bus.wb_i_byte_off  = off;
    bus.wb_i_flush     = fl;
    bus.wb_i_rf_ready  = rdy;
    bus.wb_i_fwd_addr  = fa;
  endtask

  task automatic idle(input logic [1:0] rdy);
    drive(1'b0, 7'h33, 3'd0, 5'd0, 32'd0, 32'd0, 2'd0, 1'b0, rdy, 5'd0);
  endtask

  // Entered 1 time unit after a rising edge; checks mid-cycle, then advances the model.
  task automatic run_cycle();
    logic        acc;
    logic [31:0] v;
    int          n;
    logic [1:0]  exp_we;
    logic        hit;
    logic [31:0] fd;
    #3;
    acc = bus.wb_i_ce && bus.wb_i_we_rd && bus.wb_i_rd_addr != 0 && !bus.wb_i_flush
          && q.size() < DEPTH;
    v = load_value(bus.wb_i_opcode, bus.wb_i_funct, bus.wb_i_rd_data,
                   bus.wb_i_data_load, bus.wb_i_byte_off);
    n = 0;
    while (n < q.size() && n < NP && bus.wb_i_rf_ready[n]) n++;
    exp_we = '0;
    for (int k = 0; k < n; k++) begin
      exp_we[k] = 1'b1;
      for (int j = k + 1; j < n; j++)
        if (q[j].addr == q[k].addr) exp_we[k] = 1'b0;
    end
    hit = 1'b0;
    fd  = '0;
    if (bus.wb_i_fwd_addr != 0) begin
      if (acc && bus.wb_i_rd_addr == bus.wb_i_fwd_addr) begin
        hit = 1'b1;
        fd  = v;
      end else begin
        for (int i = q.size() - 1; i >= 0; i--)
          if (q[i].addr == bus.wb_i_fwd_addr) begin
            hit = 1'b1;
            fd  = q[i].data;
            break;
          end
      end
    end
    check_val("stall", 64'(bus.wb_o_stall), 64'(q.size() == DEPTH));
    check_val("count", 64'(bus.wb_o_count), 64'(q.size()));
    check_val("we", 64'(bus.wb_o_we), 64'(exp_we));
    for (int k = 0; k < NP; k++)
      if (exp_we[k]) begin
        check_val("lane_addr", 64'(bus.wb_o_rd_addr[k*AW +: AW]), 64'(q[k].addr));
        check_val("lane_data", 64'(bus.wb_o_rd_data[k*DW +: DW]), 64'(q[k].data));
      end
    check_val("fwd_hit", 64'(bus.wb_o_fwd_hit), 64'(hit));
    check_val("fwd_data", 64'(bus.wb_o_fwd_data), 64'(fd));
    @(posedge clk);
    repeat (n) void'(q.pop_front());
    if (acc) q.push_back('{addr: bus.wb_i_rd_addr, data: v});
    #1;
  endtask

  initial begin
    idle(2'b11);
    #2;
    check_val("rst_count", 64'(bus.wb_o_count), 64'd0);
    check_val("rst_stall", 64'(bus.wb_o_stall), 64'd0);
    check_val("rst_we", 64'(bus.wb_o_we), 64'd0);
    check_val("rst_hit", 64'(bus.wb_o_fwd_hit), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single write, one-cycle latency to the port
    drive(1'b1, 7'h33, 3'd0, 5'd5, 32'h1234, 32'd0, 2'd0, 1'b0, 2'b11, 5'd0);
    run_cycle();
    idle(2'b11);
    #2;
    check_val("first_we", 64'(bus.wb_o_we), 64'b01);
    check_val("first_addr", 64'(bus.wb_o_rd_addr[AW-1:0]), 64'd5);
    check_val("first_data", 64'(bus.wb_o_rd_data[DW-1:0]), 64'h1234);
    run_cycle();
    check_val("first_count", 64'(bus.wb_o_count), 64'd0);

    // Load formatting observed through the forwarding path of the incoming entry
    drive(1'b1, 7'h03, 3'd0, 5'd1, 32'd0, 32'h80FF7F01, 2'd3, 1'b0, 2'b11, 5'd1);
    #2 check_val("lb", 64'(bus.wb_o_fwd_data), 64'hFFFFFF80);
    run_cycle();
    drive(1'b1, 7'h03, 3'd4, 5'd2, 32'd0, 32'h80FF7F01, 2'd3, 1'b0, 2'b11, 5'd2);
    #2 check_val("lbu", 64'(bus.wb_o_fwd_data), 64'h00000080);
    run_cycle();
    drive(1'b1, 7'h03, 3'd1, 5'd3, 32'd0, 32'h80FF7F01, 2'd2, 1'b0, 2'b11, 5'd3);
    #2 check_val("lh", 64'(bus.wb_o_fwd_data), 64'hFFFF80FF);
    run_cycle();
    drive(1'b1, 7'h03, 3'd5, 5'd4, 32'd0, 32'h80FF7F01, 2'd1, 1'b0, 2'b11, 5'd4);
    #2 check_val("lhu", 64'(bus.wb_o_fwd_data), 64'h00007F01);
    run_cycle();
    idle(2'b11);
    repeat (3) run_cycle();

    // Fill, drop when full, prefix rule
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 7'h33, 3'd0, 5'(k), 32'(k * 16), 32'd0, 2'd0, 1'b0, 2'b00, 5'd0);
      run_cycle();
    end
    check_val("full_stall", 64'(bus.wb_o_stall), 64'd1);
    check_val("full_count", 64'(bus.wb_o_count), 64'd4);
    drive(1'b1, 7'h33, 3'd0, 5'd5, 32'h55, 32'd0, 2'd0, 1'b0, 2'b00, 5'd5);
    run_cycle();
    idle(2'b10);
    #2 check_val("prefix_we", 64'(bus.wb_o_we), 64'b00);
    run_cycle();
    idle(2'b11);
    #2 check_val("pair_we", 64'(bus.wb_o_we), 64'b11);
    run_cycle();
    check_val("pair_count", 64'(bus.wb_o_count), 64'd2);
    repeat (2) run_cycle();

    // Same-address collision: younger wins
    drive(1'b1, 7'h33, 3'd0, 5'd7, 32'hA, 32'd0, 2'd0, 1'b0, 2'b00, 5'd0);
    run_cycle();
    drive(1'b1, 7'h33, 3'd0, 5'd7, 32'hB, 32'd0, 2'd0, 1'b0, 2'b00, 5'd0);
    run_cycle();
    idle(2'b11);
    #2;
    check_val("coll_we", 64'(bus.wb_o_we), 64'b10);
    check_val("coll_data", 64'(bus.wb_o_rd_data[DW +: DW]), 64'hB);
    run_cycle();

    // Forwarding priority: incoming beats buffered; address 0 never hits
    drive(1'b1, 7'h33, 3'd0, 5'd3, 32'h11, 32'd0, 2'd0, 1'b0, 2'b00, 5'd0);
    run_cycle();
    drive(1'b1, 7'h33, 3'd0, 5'd3, 32'h22, 32'd0, 2'd0, 1'b0, 2'b00, 5'd3);
    #1;
    check_val("fwd_in_hit", 64'(bus.wb_o_fwd_hit), 64'd1);
    check_val("fwd_in_data", 64'(bus.wb_o_fwd_data), 64'h22);
    bus.wb_i_fwd_addr = 5'd0;
    #1 check_val("fwd_zero", 64'(bus.wb_o_fwd_hit), 64'd0);
    run_cycle();

    // Flush drops the incoming result only
    drive(1'b1, 7'h33, 3'd0, 5'd9, 32'h99, 32'd0, 2'd0, 1'b1, 2'b00, 5'd9);
    run_cycle();
    check_val("flush_count", 64'(bus.wb_o_count), 64'd2);
    drive(1'b1, 7'h33, 3'd0, 5'd9, 32'h99, 32'd0, 2'd0, 1'b0, 2'b00, 5'd0);
    run_cycle();
    check_val("pre_rst_count", 64'(bus.wb_o_count), 64'd3);

    // Asynchronous reset with pending writes
    idle(2'b11);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_count", 64'(bus.wb_o_count), 64'd0);
    check_val("mid_rst_we", 64'(bus.wb_o_we), 64'd0);
    check_val("mid_rst_stall", 64'(bus.wb_o_stall), 64'd0);
    q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic, small register range to provoke collisions and hits
    for (int c = 0; c < 500; c++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 1) == 0) ? 7'b0000011 : 7'h33;
      drive($urandom_range(0, 9) < 7, op, 3'($urandom), 5'($urandom_range(0, 7)),
            $urandom, $urandom, 2'($urandom), $urandom_range(0, 9) == 0,
            2'($urandom), 5'($urandom_range(0, 7)));
      bus.wb_i_we_rd = ($urandom_range(0, 7) != 0);
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_commit_buffer.md
Name: wb_commit_buffer

Overview:
- Parametrised successor to the single-entry write-back stage.
- Sits between the memory stage and the register file.
- Formats load data, then queues register writes in a DEPTH-entry in-order buffer.
- Retires up to NPORTS writes per cycle through independently-ready register-file write ports, and provides a forwarding lookup to decode.

Parameters:
DWIDTH, 32, data width
AWIDTH, 5, register address width
FUNCT_WIDTH, 3, funct3 width
OPCODE_WIDTH, 7, opcode width
DEPTH, 4, buffer entries (power of 2, >= NPORTS)
NPORTS, 2, register-file write ports (1..4)

Ports:
wb_clk  input  1  clock
wb_rst  input  1  reset; asynchronous, active-low
wb_i_ce  input  1  memory-stage result valid
wb_i_opcode  input  OPCODE_WIDTH  instruction opcode
wb_i_funct  input  FUNCT_WIDTH  funct3
wb_i_we_rd  input  1  instruction writes rd
wb_i_rd_addr  input  AWIDTH  destination register
wb_i_rd_data  input  DWIDTH  ALU/jump result
wb_i_data_load  input  DWIDTH  raw memory word
wb_i_byte_off  input  2  load address bits [1:0]
wb_i_flush  input  1  kill incoming result
wb_i_rf_ready  input  NPORTS  per-port register-file accept
wb_i_fwd_addr  input  AWIDTH  decode source lookup
wb_o_stall  output  1  buffer full, upstream must hold
wb_o_we  output  NPORTS  write-port enables, lane 0 oldest
wb_o_rd_addr  output  NPORTS*AWIDTH  write addresses, lane k at [k*AWIDTH +: AWIDTH]
wb_o_rd_data  output  NPORTS*DWIDTH  write data, lane k at [k*DWIDTH +: DWIDTH]
wb_o_fwd_hit  output  1  lookup matched pending write
wb_o_fwd_data  output  DWIDTH  forwarded value
wb_o_count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (wb_rst=0, async): head, tail and count cleared; all entries invalid. All outputs therefore 0: wb_o_we, wb_o_stall, wb_o_fwd_hit, wb_o_count.
- Accept: wb_i_ce & wb_i_we_rd & (wb_i_rd_addr!=0) & !wb_i_flush & !wb_o_stall. On an accepted cycle the entry is written at tail on the clock edge. Non-accepted inputs are dropped silently. Upstream holds its data while wb_o_stall=1.
- wb_o_stall = (count==DEPTH), combinational from registered count. A full-buffer input is never accepted, even if drain frees space in the same cycle.
- Load formatting (opcode 7'b0000011) happens at enqueue:
  - 000 LB: sign-extend byte[off]
  - 001 LH: sign-extend half[off[1]]; off[0] ignored
  - 010 LW: full word
  - 100 LBU: zero-extend byte[off]
  - 101 LHU: zero-extend half[off[1]]
  - other funct3: full word
- Non-load opcodes store wb_i_rd_data.
- Drain (combinational from registered state):
  - Lane k presents entry head+k if k < count.
  - Lane k retires iff it is presented, wb_i_rf_ready[k]=1, and lanes 0..k-1 all retire (strict in-order prefix).
  - wb_o_we[k] = retire_k. Head advances and count decreases by the number retired.
- Same-cycle address collision: if retiring lanes i<j carry the same address, wb_o_we[i] is forced 0 and lane i still counts as retired (younger wins).
- Simultaneous accept and retire: count_next = count + accept − retired. Pointers wrap modulo DEPTH.
- Forwarding:
  - Priority order: the incoming accepted entry first, then buffer entries from youngest to oldest. Entries retiring this cycle are still visible to the lookup.
  - wb_i_fwd_addr==0 gives hit=0, data=0. No match gives hit=0, data=0.
- Flush kills only the incoming result. Buffered entries are older and always commit.
- Reset mid-operation discards all pending writes; no write enable is asserted on the reset cycle.

Test Plan:
- Reset, then accept rd=5, data 0x1234, rf_ready=2'b11 -> next cycle wb_o_we=2'b01, addr 5, data 0x1234; following cycle count=0.
- LB with raw 0x80FF7F01 at off=3 -> 0xFFFFFF80. LBU off=3 -> 0x00000080. LH off=2 -> 0xFFFF80FF. LHU off=1 -> 0x00007F01.
- rf_ready=0 with 4 accepts (r1..r4) -> stall=1, count=4, 5th input dropped. Then rf_ready=2'b10 -> no retire (prefix rule). Then 2'b11 -> r1, r2 retire; count=2.
- Buffer holds r7=0xA then r7=0xB, both retiring together -> we=2'b10, only 0xB written.
- Buffer holds r3=0x11; incoming accepted r3=0x22; fwd_addr=3 -> hit=1, data 0x22. fwd_addr=0 -> hit=0.
- Accept with flush=1 -> no enqueue. Assert wb_rst low with 3 pending -> immediately count=0, we=0, stall=0.
